// File: rtl/umul_sat_acc_pkg.sv
// Shared scalar typedefs and the frame FSM state type for the multiplier
// post-processing stages.
package umul_sat_acc_pkg;

  typedef logic        bool;
  typedef logic [7:0]  u8;
  typedef logic [15:0] u16;
  typedef logic [9:0]  u10;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/umul_sat_acc_sat_add.sv
// Combinational unsigned saturating adder; clamps to all ones on carry-out.
module sat_add #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);

  logic [WIDTH:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    sat  = full[WIDTH];
    sum  = full[WIDTH] ? '1 : full[WIDTH-1:0];
  end

endmodule

// File: rtl/umul_sat_acc.sv
// Frame accumulator behind the saturating multiplier: sums ACC_LEN products
// with saturation, counts overflowed inputs, and hands the result out on valid/ready.
module umul_sat_acc
  import umul_sat_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_LEN    = 8,
  parameter int ACC_WIDTH  = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_prod,
  input  logic [DATA_WIDTH-1:0]          in_ov,
  input  logic                           in_sig_ov,
  input  logic                           clear,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           acc_out,
  output logic                           acc_sat,
  output logic [$clog2(ACC_LEN+1)-1:0]   ov_cnt
);

  localparam int CNT_W = $clog2(ACC_LEN + 1);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_DONE  = 1'b1;

  logic [0:0]           state;
  logic [CNT_W-1:0]     cnt;
  bool                  accept;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_sat;

  assign in_ready  = (state == S_ACCUM) && !clear;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  sat_add #(
    .WIDTH(ACC_WIDTH)
  ) u_sat_add (
    .a  (acc_out),
    .b  (ACC_WIDTH'(in_prod)),
    .sum(add_sum),
    .sat(add_sat)
  );

  // acc_out doubles as the running accumulator, so the result is visible
  // one cycle after the last accept with no extra output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_ACCUM;
      cnt     <= '0;
      acc_out <= '0;
      acc_sat <= 1'b0;
      ov_cnt  <= '0;
    end else if (clear) begin
      state   <= S_ACCUM;
      cnt     <= '0;
      acc_out <= '0;
      acc_sat <= 1'b0;
      ov_cnt  <= '0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (accept) begin
            acc_out <= add_sum;
            acc_sat <= acc_sat | add_sat;
            if (in_sig_ov) ov_cnt <= ov_cnt + CNT_W'(1);
            if (cnt == CNT_W'(ACC_LEN - 1)) begin
              cnt   <= '0;
              state <= S_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (out_ready) begin
            state   <= S_ACCUM;
            acc_out <= '0;
            acc_sat <= 1'b0;
            ov_cnt  <= '0;
          end
        end
      endcase
    end
  end

  // The multiplier only reports excess bits alongside its overflow flag.
  assert property (@(posedge clk) disable iff (rst)
    (accept && !in_sig_ov) |-> (in_ov == '0));

endmodule
